// File: rtl/loop_addr_table_p.sv
// Loop-address table for the loop-buffer front end.
// Trains backward-branch loop bodies and computes an unroll count with a
// restoring divide. Entries are kept in a small round-robin table. A table
// hit at the head of a fetch group drives the dispatch sequence.
module loop_addr_table_p #(
    parameter int FETCH_W   = 4,
    parameter int ADDR_W    = 16,
    parameter int ENTRIES   = 4,
    parameter int BUF_DEPTH = 64,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_vld_in,
    input  logic [FETCH_W-1:0]        bck_lp_bus_in,
    input  logic [FETCH_W*ADDR_W-1:0] pc_in,
    input  logic                      mis_pred_in,
    output logic [1:0]                lbd_state_out,
    output logic                      loop_strt_out,
    output logic                      fnsh_unrll_out,
    output logic                      stll_ftch_out,
    output logic [FETCH_W-1:0]        inst_valid_out
);
    localparam int PTR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int LANE_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_TRAIN    = 2'b01;
    localparam logic [1:0] ST_CALC     = 2'b10;
    localparam logic [1:0] ST_DISPATCH = 2'b11;

    localparam logic [CNT_W:0]    DEPTH_X  = (CNT_W+1)'(BUF_DEPTH);
    localparam logic [CNT_W:0]    FW_X     = (CNT_W+1)'(FETCH_W);
    localparam logic [CNT_W:0]    ONE_X    = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0]  STALL_TH = CNT_W'(BUF_DEPTH - FETCH_W);
    localparam logic [CNT_W-1:0]  ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  ZERO_C   = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Table storage: {valid, start, fall, num, unroll} per entry
    logic [ENTRIES-1:0] tbl_vld_r;
    logic [ADDR_W-1:0]  tbl_start_r  [ENTRIES];
    logic [ADDR_W-1:0]  tbl_fall_r   [ENTRIES];
    logic [CNT_W-1:0]   tbl_num_r    [ENTRIES];
    logic [CNT_W-1:0]   tbl_unroll_r [ENTRIES];
    logic [PTR_W-1:0]   ptr_r;

    // Control state
    logic [1:0]        state_r, state_s;
    logic [ADDR_W-1:0] start_r, start_s, fall_r, fall_s;
    logic [CNT_W-1:0]  num_r, num_s, rem_r, rem_s, quot_r, quot_s;
    logic [CNT_W-1:0]  remaining_r, remaining_s, buf_cnt_r, buf_cnt_s;
    logic [PTR_W-1:0]  act_idx_r, act_idx_s;
    logic              first_r, first_s;
    logic              strt_r, strt_s, fnsh_r, fnsh_s, stll_r;

    // Per-group decode
    logic [ADDR_W-1:0]  lane_pc_s [FETCH_W];
    logic               hit_s, same_s, bck_any_s, end_hit_s;
    logic [PTR_W-1:0]   hit_idx_s, same_idx_s, wr_idx_s;
    logic [LANE_W-1:0]  bck_lane_s, end_lane_s;
    logic [ADDR_W-1:0]  cmp_fall_s;
    logic [FETCH_W-1:0] mask_s;
    logic [CNT_W-1:0]   mask_cnt_s;
    logic [CNT_W:0]     num_sum_s, buf_sum_s;
    logic               wr_en_s, inv_en_s;

    // Table lookups: hit on lane-0 PC and match on the trained start (lowest index wins)
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = {PTR_W{1'b0}};
        same_s     = 1'b0;
        same_idx_s = {PTR_W{1'b0}};
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            // an entry with an empty body can never dispatch
            hit_s      = hit_s | (tbl_vld_r[i] && (tbl_num_r[i] != ZERO_C) &&
                                  (tbl_start_r[i] == pc_in[0 +: ADDR_W]));
            hit_idx_s  = (tbl_vld_r[i] && (tbl_num_r[i] != ZERO_C) &&
                          (tbl_start_r[i] == pc_in[0 +: ADDR_W])) ? PTR_W'(i) : hit_idx_s;
            same_s     = same_s | (tbl_vld_r[i] && (tbl_start_r[i] == start_r));
            same_idx_s = (tbl_vld_r[i] && (tbl_start_r[i] == start_r)) ? PTR_W'(i) : same_idx_s;
        end
        wr_idx_s = same_s ? same_idx_s : ptr_r;
    end

    // Lane decode: backward-branch lane, end lane, dispatch mask and its popcount
    always_comb begin
        cmp_fall_s = (state_r == ST_IDLE) ? tbl_fall_r[hit_idx_s] : fall_r;
        bck_any_s  = |bck_lp_bus_in;
        bck_lane_s = {LANE_W{1'b0}};
        end_hit_s  = 1'b0;
        end_lane_s = {LANE_W{1'b0}};
        mask_cnt_s = ZERO_C;
        for (int i = FETCH_W - 1; i >= 0; i--) begin
            lane_pc_s[i] = pc_in[i*ADDR_W +: ADDR_W];
            bck_lane_s   = bck_lp_bus_in[i] ? LANE_W'(i) : bck_lane_s;
            end_hit_s    = end_hit_s | ((lane_pc_s[i] + ONE_A) == cmp_fall_s);
            end_lane_s   = ((lane_pc_s[i] + ONE_A) == cmp_fall_s) ? LANE_W'(i) : end_lane_s;
        end
        for (int i = 0; i < FETCH_W; i++) begin
            mask_s[i]  = !end_hit_s || (LANE_W'(i) <= end_lane_s);
            mask_cnt_s = mask_cnt_s + {{(CNT_W-1){1'b0}}, mask_s[i]};
        end
        num_sum_s = {1'b0, num_r} + (end_hit_s ? ((CNT_W+1)'(end_lane_s) + ONE_X) : FW_X);
        buf_sum_s = {1'b0, buf_cnt_r} + {1'b0, mask_cnt_s};
    end

    // Lanes past the loop end are masked only while dispatching
    always_comb begin
        if (state_r == ST_DISPATCH) begin
            inst_valid_out = mask_s;
        end else begin
            inst_valid_out = {FETCH_W{1'b1}};
        end
    end

    // Next-state and datapath update for train, divide and dispatch
    always_comb begin
        state_s     = state_r;
        start_s     = start_r;
        fall_s      = fall_r;
        num_s       = num_r;
        rem_s       = rem_r;
        quot_s      = quot_r;
        remaining_s = remaining_r;
        buf_cnt_s   = buf_cnt_r;
        act_idx_s   = act_idx_r;
        first_s     = first_r;
        strt_s      = 1'b0;
        fnsh_s      = 1'b0;
        wr_en_s     = 1'b0;
        inv_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_vld_in && hit_s) begin
                    // the hit group is counted as the first dispatch group
                    act_idx_s   = hit_idx_s;
                    fall_s      = tbl_fall_r[hit_idx_s];
                    strt_s      = 1'b1;
                    buf_cnt_s   = mask_cnt_s;
                    remaining_s = tbl_unroll_r[hit_idx_s] - {{(CNT_W-1){1'b0}}, end_hit_s};
                    if (remaining_s == ZERO_C) begin
                        fnsh_s = 1'b1;
                    end else begin
                        state_s = ST_DISPATCH;
                    end
                end else if (fetch_vld_in && bck_any_s) begin
                    fall_s  = lane_pc_s[bck_lane_s] + ONE_A;
                    num_s   = ZERO_C;
                    first_s = 1'b1;
                    state_s = ST_TRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TRAIN: begin
                if (mis_pred_in) begin
                    state_s = ST_IDLE;
                end else if (fetch_vld_in) begin
                    if (num_sum_s > DEPTH_X) begin
                        state_s = ST_IDLE;
                    end else begin
                        num_s   = num_sum_s[CNT_W-1:0];
                        first_s = 1'b0;
                        start_s = first_r ? lane_pc_s[0] : start_r;
                        if (end_hit_s) begin
                            rem_s   = DEPTH_C;
                            quot_s  = ZERO_C;
                            state_s = ST_CALC;
                        end else begin
                            state_s = ST_TRAIN;
                        end
                    end
                end else begin
                    state_s = ST_TRAIN;
                end
            end
            ST_CALC: begin
                // one restoring-subtract step per cycle: quot = BUF_DEPTH / num
                if ((num_r != ZERO_C) && (rem_r >= num_r)) begin
                    rem_s  = rem_r - num_r;
                    quot_s = quot_r + ONE_C;
                end else begin
                    wr_en_s = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (mis_pred_in) begin
                    inv_en_s = 1'b1;
                    state_s  = ST_IDLE;
                end else if (fetch_vld_in) begin
                    buf_cnt_s = buf_sum_s[CNT_W] ? {CNT_W{1'b1}} : buf_sum_s[CNT_W-1:0];
                    if (end_hit_s) begin
                        remaining_s = remaining_r - ONE_C;
                        if (remaining_s == ZERO_C) begin
                            fnsh_s  = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_DISPATCH;
                        end
                    end else begin
                        state_s = ST_DISPATCH;
                    end
                end else begin
                    state_s = ST_DISPATCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control registers and registered pulse/stall outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            start_r     <= {ADDR_W{1'b0}};
            fall_r      <= {ADDR_W{1'b0}};
            num_r       <= ZERO_C;
            rem_r       <= ZERO_C;
            quot_r      <= ZERO_C;
            remaining_r <= ZERO_C;
            buf_cnt_r   <= ZERO_C;
            act_idx_r   <= {PTR_W{1'b0}};
            first_r     <= 1'b0;
            strt_r      <= 1'b0;
            fnsh_r      <= 1'b0;
            stll_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            start_r     <= start_s;
            fall_r      <= fall_s;
            num_r       <= num_s;
            rem_r       <= rem_s;
            quot_r      <= quot_s;
            remaining_r <= remaining_s;
            buf_cnt_r   <= buf_cnt_s;
            act_idx_r   <= act_idx_s;
            first_r     <= first_s;
            strt_r      <= strt_s;
            fnsh_r      <= fnsh_s;
            stll_r      <= (state_s == ST_DISPATCH) && (buf_cnt_s >= STALL_TH);
        end
    end

    // Table write after divide (overwrite same start, else round-robin) and dispatch invalidation
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_vld_r <= {ENTRIES{1'b0}};
            ptr_r     <= {PTR_W{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_start_r[i]  <= {ADDR_W{1'b0}};
                tbl_fall_r[i]   <= {ADDR_W{1'b0}};
                tbl_num_r[i]    <= ZERO_C;
                tbl_unroll_r[i] <= ZERO_C;
            end
        end else if (wr_en_s) begin
            tbl_vld_r[wr_idx_s]    <= 1'b1;
            tbl_start_r[wr_idx_s]  <= start_r;
            tbl_fall_r[wr_idx_s]   <= fall_r;
            tbl_num_r[wr_idx_s]    <= num_r;
            tbl_unroll_r[wr_idx_s] <= quot_r;
            ptr_r                  <= same_s ? ptr_r : (ptr_r + {{(PTR_W-1){1'b0}}, 1'b1});
        end else if (inv_en_s) begin
            tbl_vld_r[act_idx_r] <= 1'b0;
        end
    end

    assign lbd_state_out  = state_r;
    assign loop_strt_out  = strt_r;
    assign fnsh_unrll_out = fnsh_r;
    assign stll_ftch_out  = stll_r;

endmodule

// File: tb/tb_loop_addr_table_p.sv
// Directed self-checking bench for loop_addr_table_p (default parameters).
module tb_loop_addr_table_p;
    logic        clk;
    logic        rst;
    logic        fetch_vld_in;
    logic [3:0]  bck_lp_bus_in;
    logic [63:0] pc_in;
    logic        mis_pred_in;
    logic [1:0]  lbd_state_out;
    logic        loop_strt_out;
    logic        fnsh_unrll_out;
    logic        stll_ftch_out;
    logic [3:0]  inst_valid_out;

    int n_tests = 0;
    int n_fail  = 0;

    loop_addr_table_p dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_vld_in   (fetch_vld_in),
        .bck_lp_bus_in  (bck_lp_bus_in),
        .pc_in          (pc_in),
        .mis_pred_in    (mis_pred_in),
        .lbd_state_out  (lbd_state_out),
        .loop_strt_out  (loop_strt_out),
        .fnsh_unrll_out (fnsh_unrll_out),
        .stll_ftch_out  (stll_ftch_out),
        .inst_valid_out (inst_valid_out)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_grp(input logic [15:0] base, input logic [3:0] bck, input logic vld, input logic mp);
        for (int i = 0; i < 4; i++) pc_in[i*16 +: 16] = base + 16'(i);
        bck_lp_bus_in = bck;
        fetch_vld_in  = vld;
        mis_pred_in   = mp;
    endtask

    task automatic set_idle();
        fetch_vld_in  = 1'b0;
        bck_lp_bus_in = 4'b0000;
        mis_pred_in   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (lbd_state_out != 2'b00 && n < 200) begin
            tick();
            n++;
        end
        check_val(tag, 32'(lbd_state_out), 32'h0);
    endtask

    // one-group loop: idle group with backward branch, then one body group ending in an end lane
    task automatic train_loop(input logic [15:0] ib, input logic [3:0] bck, input logic [15:0] sb, input string tag);
        set_grp(ib, bck, 1'b1, 1'b0);
        tick();
        set_grp(sb, 4'b0000, 1'b1, 1'b0);
        tick();
        set_idle();
        check_val({tag, "_calc"}, 32'(lbd_state_out), 32'h2);
        wait_idle(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pc_in = 64'h0;
        set_idle();
        tick();
        tick();
        check_val("rst_state", 32'(lbd_state_out), 32'h0);
        check_val("rst_strt", 32'(loop_strt_out), 32'h0);
        check_val("rst_fnsh", 32'(fnsh_unrll_out), 32'h0);
        check_val("rst_stll", 32'(stll_ftch_out), 32'h0);
        check_val("rst_ivld", 32'(inst_valid_out), 32'hF);
        check_val("rst_tbl_vld", 32'(dut.tbl_vld_r), 32'h0);
        rst = 1'b0;
        tick();

        // 6-instruction loop 0x10..0x15, branch at 0x15
        set_grp(16'h0012, 4'b1000, 1'b1, 1'b0);
        tick();
        check_val("tr_state_train", 32'(lbd_state_out), 32'h1);
        set_grp(16'h0010, 4'b0000, 1'b1, 1'b0);
        #1;
        check_val("tr_ivld_train", 32'(inst_valid_out), 32'hF);
        tick();
        check_val("tr_state_train2", 32'(lbd_state_out), 32'h1);
        set_grp(16'h0014, 4'b0000, 1'b1, 1'b0);
        tick();
        set_idle();
        check_val("tr_state_calc", 32'(lbd_state_out), 32'h2);
        check_val("tr_num", 32'(dut.num_r), 32'd6);
        check_val("tr_ivld_calc", 32'(inst_valid_out), 32'hF);
        wait_idle("tr_calc_done");
        check_val("tr_e0_vld", 32'(dut.tbl_vld_r), 32'h1);
        check_val("tr_e0_start", 32'(dut.tbl_start_r[0]), 32'h10);
        check_val("tr_e0_fall", 32'(dut.tbl_fall_r[0]), 32'h16);
        check_val("tr_e0_num", 32'(dut.tbl_num_r[0]), 32'd6);
        check_val("tr_e0_unroll", 32'(dut.tbl_unroll_r[0]), 32'd10);
        check_val("tr_ptr", 32'(dut.ptr_r), 32'd1);

        // dispatch: 10 iterations of {0x10..0x13, 0x14..0x17}
        for (int it = 0; it < 10; it++) begin
            set_grp(16'h0010, 4'b0000, 1'b1, 1'b0);
            #1;
            check_val("dp_ivld_a", 32'(inst_valid_out), 32'hF);
            tick();
            check_val("dp_strt_a", 32'(loop_strt_out), (it == 0) ? 32'h1 : 32'h0);
            check_val("dp_state_a", 32'(lbd_state_out), 32'h3);
            check_val("dp_stll_a", 32'(stll_ftch_out), 32'h0);
            set_grp(16'h0014, 4'b0000, 1'b1, 1'b0);
            #1;
            check_val("dp_ivld_b", 32'(inst_valid_out), 32'h3);
            tick();
            check_val("dp_strt_b", 32'(loop_strt_out), 32'h0);
            check_val("dp_fnsh_b", 32'(fnsh_unrll_out), (it == 9) ? 32'h1 : 32'h0);
            check_val("dp_state_b", 32'(lbd_state_out), (it == 9) ? 32'h0 : 32'h3);
            check_val("dp_stll_b", 32'(stll_ftch_out), 32'h0);
        end
        set_idle();
        tick();
        check_val("dp_fnsh_clr", 32'(fnsh_unrll_out), 32'h0);
        check_val("dp_e0_still_vld", 32'(dut.tbl_vld_r), 32'h1);

        // misprediction on the third iteration
        for (int it = 0; it < 2; it++) begin
            set_grp(16'h0010, 4'b0000, 1'b1, 1'b0);
            tick();
            set_grp(16'h0014, 4'b0000, 1'b1, 1'b0);
            tick();
        end
        set_grp(16'h0010, 4'b0000, 1'b1, 1'b0);
        tick();
        set_grp(16'h0014, 4'b0000, 1'b1, 1'b1);
        tick();
        set_idle();
        check_val("mp_state", 32'(lbd_state_out), 32'h0);
        check_val("mp_fnsh", 32'(fnsh_unrll_out), 32'h0);
        check_val("mp_e0_inval", 32'(dut.tbl_vld_r), 32'h0);
        tick();
        check_val("mp_fnsh_later", 32'(fnsh_unrll_out), 32'h0);
        set_grp(16'h0010, 4'b0000, 1'b1, 1'b0);
        tick();
        set_idle();
        check_val("mp_nohit_state", 32'(lbd_state_out), 32'h0);
        check_val("mp_nohit_strt", 32'(loop_strt_out), 32'h0);

        // oversize body: 17 groups without an end lane
        set_grp(16'h0100, 4'b1000, 1'b1, 1'b0);
        tick();
        for (int g = 0; g < 17; g++) begin
            set_grp(16'h0200 + 16'(4 * g), 4'b0000, 1'b1, 1'b0);
            tick();
            if (g == 15) check_val("ov_state_64", 32'(lbd_state_out), 32'h1);
        end
        set_idle();
        check_val("ov_state_abort", 32'(lbd_state_out), 32'h0);
        check_val("ov_no_write", 32'(dut.tbl_vld_r), 32'h0);
        check_val("ov_ptr", 32'(dut.ptr_r), 32'd1);

        // reset during CALC (1-instruction body makes a long divide)
        set_grp(16'h0080, 4'b0001, 1'b1, 1'b0);
        tick();
        set_grp(16'h0080, 4'b0000, 1'b1, 1'b0);
        tick();
        set_idle();
        tick();
        tick();
        check_val("rc_state_calc", 32'(lbd_state_out), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rc_state", 32'(lbd_state_out), 32'h0);
        check_val("rc_outs", 32'({loop_strt_out, fnsh_unrll_out, stll_ftch_out}), 32'h0);
        check_val("rc_tbl_vld", 32'(dut.tbl_vld_r), 32'h0);
        check_val("rc_ptr", 32'(dut.ptr_r), 32'd0);
        repeat (80) tick();
        check_val("rc_no_late_write", 32'(dut.tbl_vld_r), 32'h0);

        // replacement: four loops fill the table, retrain 0x10, fifth loop evicts entry0
        train_loop(16'h0011, 4'b0100, 16'h0010, "rp_l1");
        train_loop(16'h0020, 4'b1000, 16'h0020, "rp_l2");
        train_loop(16'h0030, 4'b0010, 16'h0030, "rp_l3");
        train_loop(16'h0040, 4'b0100, 16'h0040, "rp_l4");
        check_val("rp_full_vld", 32'(dut.tbl_vld_r), 32'hF);
        check_val("rp_ptr_wrap", 32'(dut.ptr_r), 32'd0);
        check_val("rp_e2_unroll", 32'(dut.tbl_unroll_r[2]), 32'd32);
        check_val("rp_e3_unroll", 32'(dut.tbl_unroll_r[3]), 32'd21);
        train_loop(16'h0011, 4'b0010, 16'h0010, "rp_retrain");
        check_val("rp_rt_fall", 32'(dut.tbl_fall_r[0]), 32'h13);
        check_val("rp_rt_num", 32'(dut.tbl_num_r[0]), 32'd3);
        check_val("rp_rt_unroll", 32'(dut.tbl_unroll_r[0]), 32'd21);
        check_val("rp_rt_ptr", 32'(dut.ptr_r), 32'd0);
        train_loop(16'h0050, 4'b0001, 16'h0050, "rp_l5");
        check_val("rp_l5_start", 32'(dut.tbl_start_r[0]), 32'h50);
        check_val("rp_l5_unroll", 32'(dut.tbl_unroll_r[0]), 32'd64);
        check_val("rp_l5_ptr", 32'(dut.ptr_r), 32'd1);
        set_grp(16'h0010, 4'b0000, 1'b1, 1'b0);
        tick();
        set_idle();
        check_val("rp_evicted_state", 32'(lbd_state_out), 32'h0);
        check_val("rp_evicted_strt", 32'(loop_strt_out), 32'h0);

        // stall: 4-instruction loop at 0x20, unroll 16, buf_cnt reaches 60 on group 15
        for (int k = 1; k <= 16; k++) begin
            set_grp(16'h0020, 4'b0000, 1'b1, 1'b0);
            tick();
            check_val("st_strt", 32'(loop_strt_out), (k == 1) ? 32'h1 : 32'h0);
            check_val("st_stll", 32'(stll_ftch_out), (k == 15) ? 32'h1 : 32'h0);
            check_val("st_fnsh", 32'(fnsh_unrll_out), (k == 16) ? 32'h1 : 32'h0);
            check_val("st_state", 32'(lbd_state_out), (k == 16) ? 32'h0 : 32'h3);
        end
        set_idle();
        tick();

        // 1-instruction loop at 0xFFFF: fall wraps to 0
        train_loop(16'hFFFC, 4'b1000, 16'hFFFF, "wr_train");
        check_val("wr_start", 32'(dut.tbl_start_r[1]), 32'hFFFF);
        check_val("wr_fall", 32'(dut.tbl_fall_r[1]), 32'h0);
        check_val("wr_num", 32'(dut.tbl_num_r[1]), 32'd1);
        check_val("wr_unroll", 32'(dut.tbl_unroll_r[1]), 32'd64);
        check_val("wr_ptr", 32'(dut.ptr_r), 32'd2);
        set_grp(16'hFFFF, 4'b0000, 1'b1, 1'b0);
        tick();
        check_val("wr_hit_state", 32'(lbd_state_out), 32'h3);
        check_val("wr_hit_strt", 32'(loop_strt_out), 32'h1);
        #1;
        check_val("wr_ivld_mask", 32'(inst_valid_out), 32'h1);
        set_grp(16'hFFFF, 4'b0000, 1'b1, 1'b1);
        tick();
        set_idle();
        check_val("wr_mp_state", 32'(lbd_state_out), 32'h0);
        check_val("wr_mp_inval", 32'(dut.tbl_vld_r), 32'hD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
